// File: rtl/mux_n_reg_pkg.sv
// Shared encodings for the registered N:1 operand-select stage.
package mux_n_reg_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/mux_n_reg.sv
// Registered N:1 operand select with load enable, out-of-range detection
// and a scan mode that streams every channel out on consecutive cycles.
module mux_n_reg
   import mux_n_reg_pkg::*;
#(
   parameter int word_size  = 32,
   parameter int num_inputs = 4,
   parameter int sel_width  = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [num_inputs*word_size-1:0] in,
   input  logic [sel_width-1:0]            sel,
   input  logic                            mode,
   input  logic                            load,
   output logic [word_size-1:0]            out,
   output logic                            out_valid,
   output logic                            sel_err,
   output logic                            busy,
   output logic [sel_width-1:0]            scan_idx,
   output logic                            scan_done
);

   localparam int base_width = $clog2(num_inputs * word_size);
   localparam logic [sel_width-1:0] last_idx = sel_width'(num_inputs - 1);

   state_t                 state_r;
   logic [sel_width-1:0]   cnt_r;
   logic                   sel_ok_s;
   logic [sel_width-1:0]   rd_idx_s;
   logic [base_width-1:0]  base_s;
   logic [word_size-1:0]   word_s;

   // Read index: scan counter while scanning, else channel 0 for a scan
   // start or a bad select, else the direct select (keeps the part-select in range).
   always_comb begin
      sel_ok_s = (32'(sel) < 32'(num_inputs));
      if (state_r == ST_SCAN) begin
         rd_idx_s = cnt_r;
      end else if ((mode == MODE_SCAN) || !sel_ok_s) begin
         rd_idx_s = {sel_width{1'b0}};
      end else begin
         rd_idx_s = sel;
      end
      base_s = base_width'(32'(rd_idx_s) * 32'(word_size));
      word_s = in[base_s +: word_size];
   end

   // Control FSM and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {sel_width{1'b0}};
         out       <= {word_size{1'b0}};
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
         busy      <= 1'b0;
         scan_idx  <= {sel_width{1'b0}};
         scan_done <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         scan_done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (load) begin
                  out_valid <= 1'b1;
                  if (mode == MODE_SCAN) begin
                     out      <= word_s;
                     scan_idx <= {sel_width{1'b0}};
                     sel_err  <= 1'b0;
                     cnt_r    <= sel_width'(1);
                     busy     <= 1'b1;
                     state_r  <= ST_SCAN;
                  end else begin
                     out      <= sel_ok_s ? word_s : {word_size{1'b0}};
                     sel_err  <= !sel_ok_s;
                     scan_idx <= rd_idx_s;
                  end
               end
            end
            ST_SCAN: begin
               out       <= word_s;
               scan_idx  <= cnt_r;
               out_valid <= 1'b1;
               // Counter stops at the last channel, so it never wraps.
               if (cnt_r == last_idx) begin
                  scan_done <= 1'b1;
                  busy      <= 1'b0;
                  cnt_r     <= {sel_width{1'b0}};
                  state_r   <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + sel_width'(1);
               end
            end
            default: begin
               busy    <= 1'b0;
               cnt_r   <= {sel_width{1'b0}};
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_n_reg.sv
// Table-driven scoreboard bench for mux_n_reg: a 4-channel and a
// 5-channel instance, expected words queued at drive time and popped at the negedge.
module tb_mux_n_reg;

   typedef struct packed {
      logic [31:0] out;
      logic        v;
      logic        err;
      logic        busy;
      logic [2:0]  idx;
      logic        done;
   } exp_t;

   typedef struct packed {
      logic       dut;
      logic       rst;
      logic       md;
      logic       ld;
      logic [2:0] sel;
      exp_t       e;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         mode;
   logic         load4, load5;
   logic [1:0]   sel4;
   logic [2:0]   sel5;
   logic [127:0] in4;
   logic [159:0] in5;

   logic [31:0]  out4, out5;
   logic         v4, v5, err4, err5, busy4, busy5, done4, done5;
   logic [1:0]   idx4;
   logic [2:0]   idx5;

   exp_t sb_q[$];
   vec_t tbl[0:39];
   int   n_vec    = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mux_n_reg #(.word_size(32), .num_inputs(4), .sel_width(2)) dut4 (
      .clk(clk), .reset(reset), .in(in4), .sel(sel4), .mode(mode), .load(load4),
      .out(out4), .out_valid(v4), .sel_err(err4), .busy(busy4),
      .scan_idx(idx4), .scan_done(done4)
   );

   mux_n_reg #(.word_size(32), .num_inputs(5), .sel_width(3)) dut5 (
      .clk(clk), .reset(reset), .in(in5), .sel(sel5), .mode(mode), .load(load5),
      .out(out5), .out_valid(v5), .sel_err(err5), .busy(busy5),
      .scan_idx(idx5), .scan_done(done5)
   );

   function automatic vec_t mk(logic dut, logic rst, logic md, logic ld, logic [2:0] sel,
                               logic [31:0] o, logic v, logic err, logic busy,
                               logic [2:0] idx, logic done);
      vec_t r;
      r.dut = dut; r.rst = rst; r.md = md; r.ld = ld; r.sel = sel;
      r.e.out = o; r.e.v = v; r.e.err = err; r.e.busy = busy; r.e.idx = idx; r.e.done = done;
      return r;
   endfunction

   task automatic add(input vec_t r);
      tbl[n_vec] = r;
      n_vec++;
   endtask

   task automatic check(input logic dut);
      exp_t got, want;
      if (dut) got = {out5, v5, err5, busy5, idx5, done5};
      else     got = {out4, v4, err4, busy4, {1'b0, idx4}, done4};
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_empty: no expected entry for dut%0d", dut);
      end else begin
         want = sb_q.pop_front();
         if (got !== want) begin
            n_fail++;
            $display("FAIL step%0d dut%0d: got out=%h v=%b err=%b busy=%b idx=%0d done=%b, required out=%h v=%b err=%b busy=%b idx=%0d done=%b",
                     n_checks, dut, got.out, got.v, got.err, got.busy, got.idx, got.done,
                     want.out, want.v, want.err, want.busy, want.idx, want.done);
         end
      end
   endtask

   // Drive just after a negedge, capture on the posedge, compare on the next negedge.
   task automatic apply(input vec_t r);
      reset = r.rst;
      mode  = r.md;
      load4 = r.ld & ~r.dut;
      load5 = r.ld & r.dut;
      sel4  = r.sel[1:0];
      sel5  = r.sel;
      sb_q.push_back(r.e);
      @(negedge clk);
      check(r.dut);
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; load4 = 1'b0; load5 = 1'b0; sel4 = 2'd0; sel5 = 3'd0;
      in4 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      in5 = {32'hEEEE0004, in4};

      // 4-channel instance: reset over load, direct, ignored load, back-to-back, reset mid-scan
      add(mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'hDDDD0003, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hDDDD0003, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hBBBB0001, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0));
      add(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'hAAAA0000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hBBBB0001, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hCCCC0002, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hDDDD0003, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hDDDD0003, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
      add(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'hAAAA0000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hBBBB0001, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hCCCC0002, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hDDDD0003, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1));
      add(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'hAAAA0000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hBBBB0001, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0));
      add(mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      add(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 32'hCCCC0002, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0));
      // 5-channel instance: out-of-range selects, recovery, full scan
      add(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 32'h0,        1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
      add(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
      add(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 32'hEEEE0004, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0));
      add(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 32'h0,        1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
      add(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 32'hAAAA0000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0));
      add(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hBBBB0001, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0));
      add(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hCCCC0002, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0));
      add(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hDDDD0003, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0));
      add(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hEEEE0004, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1));
      add(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hEEEE0004, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));

      @(negedge clk);
      for (int i = 0; i < n_vec; i++) begin
         apply(tbl[i]);
      end

      // Channel data changing mid-scan is taken at each channel's own capture edge
      apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'hAAAA0000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0));
      in4[63:32] = 32'h11112222;
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h11112222, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0));
      in4[63:32] = 32'hBBBB0001;
      in4[95:64] = 32'h33334444;
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h33334444, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0));
      in4[95:64] = 32'hCCCC0002;
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hDDDD0003, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1));
      // Idle hold ignores channel changes
      in4[127:96] = 32'h55556666;
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hDDDD0003, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
      apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h55556666, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
